// File: rtl/alu7_rot.sv
// -----------------------------------------------------------------------------
// alu7_rot
//   Small registered ALU on WIDTH-bit operands. It supports bitwise NOT,
//   variable rotate-right, unsigned ADD and SUB. The result and its
//   carry/sign/zero flags are computed combinationally from A/B/OP. They are
//   registered on a clock edge where in_valid is high. out_valid pulses for
//   exactly one cycle after each accepted request. A request can be accepted
//   on every cycle, and there is no backpressure.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      capture A/B/OP on this clock edge
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B (rotate amount for ROR)
//   OP         in   2      00 NOT, 01 ROR, 10 ADD, 11 SUB
//   R          out  WIDTH  registered result
//   CF         out  1      registered carry / borrow / last-rotated bit
//   SF         out  1      registered sign flag (R msb)
//   ZF         out  1      registered zero flag
//   out_valid  out  1      high for one cycle when R/flags update
// -----------------------------------------------------------------------------
module alu7_rot #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    output logic [WIDTH-1:0] R,
    output logic             CF,
    output logic             SF,
    output logic             ZF,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_ROR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    op_e              op;
    logic [WIDTH-1:0] amt;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res_nxt;
    logic             cf_nxt;

    assign op = op_e'(OP);

    // The full B value is reduced modulo WIDTH. For example, with WIDTH=7,
    // B=7 rotates by 0 and B=8 rotates by 1.
    assign amt = B % WIDTH_V;

    // When amt is 0, the left-shift count equals WIDTH. That shift produces
    // all zeros, so the result is A unchanged.
    assign ror_res = (A >> amt) | (A << (WIDTH_V - amt));

    // Both results are computed one bit wider than the operands. For ADD,
    // the top bit is the carry. For SUB, the top bit is set exactly when
    // A < B, which is the unsigned borrow.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        res_nxt = '0;
        cf_nxt  = 1'b0;
        unique case (op)
            OP_NOT: begin
                res_nxt = ~A;
                cf_nxt  = 1'b0;
            end
            OP_ROR: begin
                res_nxt = ror_res;
                // The last bit rotated around ends up in the msb.
                cf_nxt  = (amt != '0) ? ror_res[WIDTH-1] : 1'b0;
            end
            OP_ADD: begin
                res_nxt = sum[WIDTH-1:0];
                cf_nxt  = sum[WIDTH];
            end
            OP_SUB: begin
                res_nxt = diff[WIDTH-1:0];
                cf_nxt  = diff[WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R         <= '0;
            CF        <= 1'b0;
            SF        <= 1'b0;
            ZF        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                R  <= res_nxt;
                CF <= cf_nxt;
                SF <= res_nxt[WIDTH-1];
                ZF <= (res_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu7_rot.sv
// -----------------------------------------------------------------------------
// tb_alu7_rot
//   Directed testbench for alu7_rot at WIDTH=7. Every expected value is a
//   hand-computed constant. Requests are issued back-to-back with in_valid
//   held high. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu7_rot;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] A;
    logic [6:0] B;
    logic [1:0] OP;
    logic [6:0] R;
    logic       CF;
    logic       SF;
    logic       ZF;
    logic       out_valid;

    int passed = 0;
    int total  = 0;

    alu7_rot #(.WIDTH(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .R         (R),
        .CF        (CF),
        .SF        (SF),
        .ZF        (ZF),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [6:0] er, input logic ecf,
                             input logic esf, input logic ezf, input logic eov);
        check_bit({tag, ".out_valid"}, out_valid, eov);
        check_vec({tag, ".R"}, R, er);
        check_bit({tag, ".CF"}, CF, ecf);
        check_bit({tag, ".SF"}, SF, esf);
        check_bit({tag, ".ZF"}, ZF, ezf);
    endtask

    // Drives one request with in_valid held high, then checks the registered
    // result just after the capturing edge.
    task automatic do_op(input string tag, input logic [6:0] a, input logic [6:0] b,
                         input logic [1:0] op, input logic [6:0] er,
                         input logic ecf, input logic esf, input logic ezf);
        A        = a;
        B        = b;
        OP       = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag, er, ecf, esf, ezf, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        OP       = 2'b00;
        #2;
        check_all("reset_init", 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // The first three requests are issued back-to-back.
        do_op("not_a55",   7'b1010101, 7'b1111111, 2'b00, 7'b0101010, 1'b0, 1'b0, 1'b0);
        do_op("not_zero",  7'b0000000, 7'b0000000, 2'b00, 7'b1111111, 1'b0, 1'b1, 1'b0);
        do_op("not_ones",  7'b1111111, 7'b0101010, 2'b00, 7'b0000000, 1'b0, 1'b0, 1'b1);

        do_op("ror_b1",    7'b1000001, 7'd1,   2'b01, 7'b1100000, 1'b1, 1'b1, 1'b0);
        do_op("ror_b2",    7'b1100001, 7'd2,   2'b01, 7'b0111000, 1'b0, 1'b0, 1'b0);
        do_op("ror_msb_b3",7'b1000000, 7'd3,   2'b01, 7'b0001000, 1'b0, 1'b0, 1'b0);
        do_op("ror_lsb_b3",7'b0000001, 7'd3,   2'b01, 7'b0010000, 1'b0, 1'b0, 1'b0);
        do_op("ror_lsb_b1",7'b0000001, 7'd1,   2'b01, 7'b1000000, 1'b1, 1'b1, 1'b0);
        do_op("ror_ones5", 7'b1111111, 7'd5,   2'b01, 7'b1111111, 1'b1, 1'b1, 1'b0);
        do_op("ror_b0",    7'b1000001, 7'd0,   2'b01, 7'b1000001, 1'b0, 1'b1, 1'b0);
        do_op("ror_b7",    7'b1000001, 7'd7,   2'b01, 7'b1000001, 1'b0, 1'b1, 1'b0);
        do_op("ror_b8",    7'b1000001, 7'd8,   2'b01, 7'b1100000, 1'b1, 1'b1, 1'b0);
        do_op("ror_b127",  7'b1000001, 7'd127, 2'b01, 7'b1100000, 1'b1, 1'b1, 1'b0);
        do_op("ror_zero",  7'b0000000, 7'd3,   2'b01, 7'b0000000, 1'b0, 1'b0, 1'b1);

        do_op("add_wrap",  7'b1111111, 7'b0000001, 2'b10, 7'b0000000, 1'b1, 1'b0, 1'b1);
        do_op("add_19_37", 7'b0010011, 7'b0100101, 2'b10, 7'b0111000, 1'b0, 1'b0, 1'b0);
        do_op("add_sign",  7'b0111111, 7'b0000001, 2'b10, 7'b1000000, 1'b0, 1'b1, 1'b0);
        do_op("sub_3_5",   7'b0000011, 7'b0000101, 2'b11, 7'b1111110, 1'b1, 1'b1, 1'b0);
        do_op("sub_eq",    7'b0000101, 7'b0000101, 2'b11, 7'b0000000, 1'b0, 1'b0, 1'b1);
        do_op("sub_64_1",  7'b1000000, 7'b0000001, 2'b11, 7'b0111111, 1'b0, 1'b0, 1'b0);

        // With in_valid low, the outputs hold the sub_64_1 values.
        in_valid = 1'b0;
        A        = 7'b1010101;
        B        = 7'b0000011;
        OP       = 2'b10;
        @(posedge clk);
        #1;
        check_all("idle1", 7'b0111111, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("idle2", 7'b0111111, 1'b0, 1'b0, 1'b0, 1'b0);

        // Assert reset mid-cycle while a request is pending. The outputs must
        // clear without waiting for a clock edge.
        do_op("pre_reset", 7'b1111111, 7'd5, 2'b01, 7'b1111111, 1'b1, 1'b1, 1'b0);
        A        = 7'b0000001;
        B        = 7'b0000001;
        OP       = 2'b10;
        in_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check_all("reset_async", 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_held", 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);

        do_op("recover",   7'b0000011, 7'b0000100, 2'b10, 7'b0000111, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_bit("recover_drop.out_valid", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
